// File: rtl/cache_victim_sel6.sv
// rtl/cache_victim_sel6.sv - 6-way victim selector with true-LRU ages and fire-pulse handshake
module cache_victim_sel6 #(
    parameter int SET_W       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_hit_vld,
    input  logic [SET_W-1:0] i_hit_set,
    input  logic [2:0]       i_hit_way,
    output logic             o_hit_rdy,
    input  logic             i_miss_req,
    input  logic [SET_W-1:0] i_miss_set,
    output logic             o_miss_rdy,
    output logic [5:0]       o_valid,
    output logic [2:0]       o_victim_way,
    input  logic             i_fire,
    output logic             o_fill_done
);
    localparam int NUM_SETS = 1 << SET_W;

    typedef enum logic [1:0] {IDLE, CALC, HOLD, COMMIT} state_t;

    state_t                 state_q, state_d;
    logic [5:0]             vbit_q [NUM_SETS];
    logic [5:0]             vbit_d [NUM_SETS];
    logic [2:0]             age_q  [NUM_SETS][6];
    logic [2:0]             age_d  [NUM_SETS][6];
    logic [SET_W-1:0]       set_q, set_d;
    logic [2:0]             victim_q, victim_d;
    logic [5:0]             valid_q, valid_d;
    logic                   fill_q, fill_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   fire_prev_q, fire_prev_d;

    logic                   fire_rise;
    logic [2:0]             inv_way, lru_way, calc_way;
    logic                   upd_en;
    logic [SET_W-1:0]       upd_set;
    logic [2:0]             upd_way, upd_old;

    assign o_hit_rdy    = !rst && (state_q != COMMIT);
    assign o_miss_rdy   = !rst && (state_q == IDLE);
    assign o_valid      = valid_q;
    assign o_victim_way = victim_q;
    assign o_fill_done  = fill_q;

    // The edge detector runs in every state so a pulse straddling HOLD entry fires once at most.
    assign sync_d      = {sync_q[SYNC_STAGES-2:0], i_fire};
    assign fire_prev_d = sync_q[SYNC_STAGES-1];
    assign fire_rise   = sync_q[SYNC_STAGES-1] & ~fire_prev_q;

    always_comb begin
        inv_way = 3'd0;
        lru_way = 3'd0;
        for (int w = 5; w >= 0; w--) begin
            if (!vbit_q[set_q][w]) inv_way = 3'(w);
            if (age_q[set_q][w] == 3'd5) lru_way = 3'(w);
        end
        calc_way = (&vbit_q[set_q]) ? lru_way : inv_way;
    end

    // Hits are never accepted in COMMIT, so a single LRU update port suffices.
    always_comb begin
        upd_en  = 1'b0;
        upd_set = i_hit_set;
        upd_way = i_hit_way;
        if (state_q == COMMIT) begin
            upd_en  = 1'b1;
            upd_set = set_q;
            upd_way = victim_q;
        end else if (o_hit_rdy && i_hit_vld && (i_hit_way <= 3'd5)) begin
            upd_en = 1'b1;
        end
        upd_old = age_q[upd_set][upd_way];
    end

    always_comb begin
        state_d  = state_q;
        set_d    = set_q;
        victim_d = victim_q;
        valid_d  = valid_q;
        fill_d   = 1'b0;
        vbit_d   = vbit_q;
        age_d    = age_q;
        case (state_q)
            IDLE: begin
                if (i_miss_req) begin
                    set_d   = i_miss_set;
                    state_d = CALC;
                end
            end
            CALC: begin
                victim_d = calc_way;
                valid_d  = 6'b000001 << calc_way;
                state_d  = HOLD;
            end
            HOLD: begin
                if (fire_rise) begin
                    valid_d = 6'b000000;
                    fill_d  = 1'b1;
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                vbit_d[set_q][victim_q] = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (upd_en) begin
            for (int w = 0; w < 6; w++) begin
                if (3'(w) == upd_way)
                    age_d[upd_set][w] = 3'd0;
                else if (age_q[upd_set][w] < upd_old)
                    age_d[upd_set][w] = age_q[upd_set][w] + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            set_q       <= '0;
            victim_q    <= 3'd0;
            valid_q     <= 6'd0;
            fill_q      <= 1'b0;
            sync_q      <= '0;
            fire_prev_q <= 1'b0;
            for (int s = 0; s < NUM_SETS; s++) begin
                vbit_q[s] <= 6'd0;
                for (int w = 0; w < 6; w++) age_q[s][w] <= 3'(w);
            end
        end else begin
            state_q     <= state_d;
            set_q       <= set_d;
            victim_q    <= victim_d;
            valid_q     <= valid_d;
            fill_q      <= fill_d;
            sync_q      <= sync_d;
            fire_prev_q <= fire_prev_d;
            vbit_q      <= vbit_d;
            age_q       <= age_d;
        end
    end
endmodule

// File: tb/tb_cache_victim_sel6.sv
// tb/tb_cache_victim_sel6.sv - randomized and directed checks against an MRU-ordered list model
module tb_cache_victim_sel6;
    localparam int SET_W = 4;
    localparam int SYNC  = 2;
    localparam int NSETS = 1 << SET_W;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             i_hit_vld = 1'b0;
    logic [SET_W-1:0] i_hit_set = '0;
    logic [2:0]       i_hit_way = 3'd0;
    logic             o_hit_rdy;
    logic             i_miss_req = 1'b0;
    logic [SET_W-1:0] i_miss_set = '0;
    logic             o_miss_rdy;
    logic [5:0]       o_valid;
    logic [2:0]       o_victim_way;
    logic             i_fire = 1'b0;
    logic             o_fill_done;

    cache_victim_sel6 #(.SET_W(SET_W), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .rst(rst),
        .i_hit_vld(i_hit_vld), .i_hit_set(i_hit_set), .i_hit_way(i_hit_way), .o_hit_rdy(o_hit_rdy),
        .i_miss_req(i_miss_req), .i_miss_set(i_miss_set), .o_miss_rdy(o_miss_rdy),
        .o_valid(o_valid), .o_victim_way(o_victim_way),
        .i_fire(i_fire), .o_fill_done(o_fill_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each set is a list of ways ordered MRU first; position in the list is the age.
    int       ord [NSETS][6];
    bit [5:0] mvb [NSETS];
    int       phase;      // 0 idle, 1 choosing, 2 waiting for fire, 3 filling
    int       mset, mvic;
    bit [5:0] exp_valid;
    bit       exp_fill;
    bit       hist [0:7];

    task automatic model_reset();
        for (int s = 0; s < NSETS; s++) begin
            mvb[s] = 6'd0;
            for (int w = 0; w < 6; w++) ord[s][w] = w;
        end
        phase = 0; mset = 0; mvic = 0; exp_valid = 6'd0; exp_fill = 1'b0;
        for (int i = 0; i < 8; i++) hist[i] = 1'b0;
    endtask

    task automatic touch(input int s, input int w);
        int p;
        p = 0;
        for (int i = 0; i < 6; i++) if (ord[s][i] == w) p = i;
        for (int i = p; i > 0; i--) ord[s][i] = ord[s][i-1];
        ord[s][0] = w;
    endtask

    function automatic int pick_victim(input int s);
        for (int w = 0; w < 6; w++) if (!mvb[s][w]) return w;
        return ord[s][5];
    endfunction

    task automatic model_step();
        bit rise, hit_ok;
        int hs, hw;
        if (rst) begin
            model_reset();
            return;
        end
        // hist[k] holds i_fire as sampled k+1 edges ago.
        rise   = hist[SYNC-1] && !hist[SYNC];
        hit_ok = i_hit_vld && (phase != 3) && (i_hit_way <= 3'd5);
        hs     = int'(i_hit_set);
        hw     = int'(i_hit_way);
        exp_fill = 1'b0;
        case (phase)
            0: if (i_miss_req) begin mset = int'(i_miss_set); phase = 1; end
            1: begin mvic = pick_victim(mset); exp_valid = 6'(1 << mvic); phase = 2; end
            2: if (rise) begin exp_valid = 6'd0; exp_fill = 1'b1; phase = 3; end
            default: begin mvb[mset][mvic] = 1'b1; touch(mset, mvic); phase = 0; end
        endcase
        if (hit_ok) touch(hs, hw);
        for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = i_fire;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("o_valid", int'(o_valid), int'(exp_valid));
            if (exp_valid != 6'd0) chk("o_victim_way", int'(o_victim_way), mvic);
            chk("o_fill_done", int'(o_fill_done), int'(exp_fill));
            chk("o_hit_rdy", int'(o_hit_rdy), (rst || phase == 3) ? 0 : 1);
            if (!rst) chk("o_miss_rdy", int'(o_miss_rdy), (phase == 0) ? 1 : 0);
        end
    end

    task automatic miss(input int s, input int expv);
        int n;
        n = 0;
        while (!o_miss_rdy && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) chk("miss_rdy_timeout", 0, 1);
        i_miss_req = 1'b1;
        i_miss_set = SET_W'(s);
        @(negedge clk);
        i_miss_req = 1'b0;
        @(negedge clk);
        chk("t_valid", int'(o_valid), expv);
    endtask

    task automatic fire();
        int n;
        i_fire = 1'b1;
        @(negedge clk);
        i_fire = 1'b0;
        n = 0;
        while (!o_fill_done && n < 10) begin @(negedge clk); n++; end
        if (n >= 10) chk("fill_timeout", 0, 1);
        @(negedge clk);
    endtask

    task automatic hit(input int s, input int w);
        i_hit_vld = 1'b1;
        i_hit_set = SET_W'(s);
        i_hit_way = 3'(w);
        @(negedge clk);
        i_hit_vld = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_valid", int'(o_valid), 0);
        chk("rst_victim", int'(o_victim_way), 0);
        chk("rst_fill", int'(o_fill_done), 0);
        chk("rst_hit_rdy", int'(o_hit_rdy), 0);
        @(posedge clk); #3 rst = 1'b0;
        @(negedge clk);

        miss(3, 6'b000001);
        fire();
        chk("t1_model_vbit", int'(mvb[3]), 1);
        chk("t1_model_mru", ord[3][0], 0);

        for (int i = 0; i < 6; i++) begin
            miss(5, 1 << i);
            fire();
        end
        miss(5, 6'b000001);
        fire();

        hit(5, 0); hit(5, 2); hit(5, 1);
        miss(5, 6'b001000);
        hit(5, 3);
        @(negedge clk);
        chk("t4_held", int'(o_valid), 6'b001000);
        fire();
        chk("t4_model_mru", ord[5][0], 3);
        chk("t4_model_lru", ord[5][5], 4);
        miss(5, 6'b010000);
        fire();

        i_fire = 1'b1;
        @(negedge clk);
        i_fire = 1'b0;
        repeat (6) @(negedge clk);
        chk("t5_no_fill", int'(o_fill_done), 0);
        miss(7, 6'b000001);
        repeat (10) @(negedge clk);
        chk("t5_still_held", int'(o_valid), 6'b000001);
        fire();

        miss(9, 6'b000001);
        @(posedge clk); #3 rst = 1'b1;
        #1 chk("t6_rst_valid", int'(o_valid), 0);
        @(posedge clk); #3 rst = 1'b0;
        @(negedge clk);
        miss(9, 6'b000001);
        fire();

        for (int c = 0; c < 2000; c++) begin
            i_hit_vld  = ($urandom_range(0, 1) == 1);
            i_hit_set  = SET_W'($urandom_range(0, 3));
            i_hit_way  = 3'($urandom_range(0, 7));
            i_miss_req = ($urandom_range(0, 3) == 0);
            i_miss_set = SET_W'($urandom_range(0, 3));
            i_fire     = ($urandom_range(0, 5) == 0);
            @(negedge clk);
        end
        i_hit_vld = 1'b0; i_miss_req = 1'b0; i_fire = 1'b0;
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
